mul_6_bit_seq: RTL
==================

// Module: mul_6_bit_seq
// PURPOSE
//  Multi-cycle unsigned 6x6 shift-and-add multiplier controller built around
//  the existing combinational adder_6_bit.
//  - Sequences one adder_6_bit instance over WIDTH iterations, one iteration
//    per clock, to produce a 12-bit product plus flags.
//  - Sits beside the ALU; the CPU control unit starts it and waits on done.
// PARAMETERS
//  WIDTH      6   operand width; must equal the adder width (only 6 supported)
//  DONE_HOLD  0   0: done is a 1-cycle pulse; 1: done/result held until next start
// PORTS
//  clk      in   1        system clock, rising edge
//  rst_n    in   1        asynchronous active-low reset
//  start    in   1        request; sampled on the rising edge of clk
//  op_a     in   WIDTH    multiplicand; captured when start is accepted
//  op_b     in   WIDTH    multiplier; captured when start is accepted
//  busy     out  1        high while in RUN
//  done     out  1        result valid (see DONE_HOLD)
//  product  out  2*WIDTH  unsigned product {hi,lo}
//  cf       out  1        product[11:6] != 0 (result does not fit in 6 bits)
//  zf       out  1        product == 0
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): state=IDLE. busy, done, product, cf, zf,
//    all internal registers and cnt = 0.
//  - Internal registers: mcand[5:0], acc[5:0] (upper half), mq[5:0]
//    (lower half / multiplier), cnt[2:0].
//  - The adder is wired with a=acc, b=mcand (b forced to 0 when mq[0]=0).
//    Its cf is the carry into the shift. Its sf/zf are unused.
//  - IDLE: start=1 -> mcand=op_a, mq=op_b, acc=0, cnt=0, busy=1 -> RUN.
//  - RUN, each cycle:
//    - {acc,mq} <= {cf_add, r_add, mq[5:1]} (7-bit carry + sum, shifted right 1).
//    - cnt++.
//    - When cnt==WIDTH-1: go to DONE, busy=0, done=1, latch product={acc,mq}
//      of the final shift, and set cf/zf from it.
//  - DONE (DONE_HOLD=0): done=1 for exactly this cycle, then IDLE with done=0.
//    product/cf/zf keep their values until the next accept.
//  - DONE_HOLD=1: remain in DONE with done=1 until start is accepted.
//  - Latency: start accepted at edge T -> busy high on cycles T+1..T+6 ->
//    done high in cycle after edge T+6 (6 clocks start-to-done).
//  - start while in RUN is ignored. Operands are not re-sampled and there is
//    no queueing.
//  - start while in DONE is accepted (same as IDLE): done drops and busy
//    rises on that edge, giving back-to-back operations with no idle cycle.
//  - op_a/op_b changes after the accept have no effect.
//  - Reset mid-RUN aborts immediately: all outputs return to reset values and
//    no done is issued.
//  - Arithmetic: pure unsigned; max 63*63=3969 fits in 12 bits. No overflow
//    beyond product width is possible.
// STRUCTURE
//  - Shared package/header (cpu_defs.vh):
//    - WORD_W=6
//    - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
//    - S_DONE is shared with other multi-cycle ALU sequencers.
//  - One sub-module: adder_6_bit (existing, positional ports a,b,r,cf,sf,zf),
//    instantiated once.
//  - FSM, counter and shift register live in this file.
// TESTING
//  1. Reset, then op_a=6'b010101 (21), op_b=6'b001100 (12), start 1 cycle ->
//     busy for 6 cycles, done pulse, product=12'h0FC, cf=1, zf=0.
//  2. op_a=63, op_b=63 -> product=12'hF81, cf=1, zf=0.
//     op_a=7, op_b=9 -> product=12'h03F, cf=0, zf=0.
//  3. op_a=6'b111100, op_b=0 -> product=0, zf=1, cf=0.
//     op_a=0, op_b=63 -> same result.
//  4. Start 21*12. Pulse start with op_a=1, op_b=1 on RUN cycle 3 ->
//     ignored, product=12'h0FC. Then start in the DONE cycle with 2*3 ->
//     accepted, next done gives product=12'h006.
//  5. Start 63*63. Assert rst_n=0 asynchronously mid-cycle in RUN cycle 4 ->
//     busy/done/product/cf/zf = 0 immediately. Release, start 5*5 -> 12'h019.
//  6. DONE_HOLD=1 build: after 21*12, done stays 1 for 10+ cycles until the
//     next start; product stable throughout.

Source files
------------

// File: rtl/mul_6_bit_seq_pkg.sv
// rtl/mul_6_bit_seq_pkg.sv - shared word width and sequencer state encodings
// Purpose : common definitions for the multi-cycle ALU sequencers.
// Ports   : none (package).
package mul_6_bit_seq_pkg;

   localparam int WORD_W = 6;
   localparam int CNT_W  = 3;

   // S_DONE is shared with the other multi-cycle ALU sequencers.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/mul_6_bit_seq_adder.sv
// rtl/mul_6_bit_seq_adder.sv - combinational 6-bit adder with carry, sign and zero flags
// Purpose : r = a + b, cf = carry out, sf = r msb, zf = (r == 0).
// Ports   : a, b (in, 6) ; r (out, 6) ; cf, sf, zf (out, 1)
module adder_6_bit
   import mul_6_bit_seq_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic [WORD_W-1:0] r,
   output logic              cf,
   output logic              sf,
   output logic              zf
);

   logic [WORD_W:0] w_sum;

   assign w_sum = {1'b0, a} + {1'b0, b};
   assign r     = w_sum[WORD_W-1:0];
   assign cf    = w_sum[WORD_W];
   assign sf    = w_sum[WORD_W-1];
   assign zf    = (w_sum[WORD_W-1:0] == '0);

endmodule

// File: rtl/mul_6_bit_seq.sv
// rtl/mul_6_bit_seq.sv - sequential unsigned 6x6 shift-and-add multiplier
// Purpose : runs one adder_6_bit over WIDTH clocks to form a 12-bit product.
// Ports   : clk, rst_n (async, active low), start, op_a, op_b (in)
//           busy, done, product[2*WIDTH-1:0], cf, zf (out)
module mul_6_bit_seq
   import mul_6_bit_seq_pkg::*;
#(
   parameter int WIDTH     = WORD_W,
   parameter bit DONE_HOLD = 1'b0
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic               cf,
   output logic               zf
);

   seq_state_t         r_state;
   seq_state_t         w_state_nxt;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_mq;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_product;
   logic               r_cf;
   logic               r_zf;

   logic [WIDTH-1:0]   w_add_b;
   logic [WIDTH-1:0]   w_add_r;
   logic               w_add_cf;
   logic               w_add_sf_unused;
   logic               w_add_zf_unused;
   logic [2*WIDTH-1:0] w_shift;
   logic               w_accept;
   logic               w_last;

   // Partial product only added when the current multiplier bit is set.
   assign w_add_b = r_mq[0] ? r_mcand : '0;

   adder_6_bit u_adder (
      .a  (r_acc),
      .b  (w_add_b),
      .r  (w_add_r),
      .cf (w_add_cf),
      .sf (w_add_sf_unused),
      .zf (w_add_zf_unused)
   );

   // Carry and sum drop into the upper half; consumed multiplier bit falls off.
   assign w_shift  = {w_add_cf, w_add_r, r_mq[WIDTH-1:1]};
   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE: begin
            if (start)           w_state_nxt = S_RUN;
            else if (!DONE_HOLD) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand   <= '0;
         r_acc     <= '0;
         r_mq      <= '0;
         r_cnt     <= '0;
         r_product <= '0;
         r_cf      <= 1'b0;
         r_zf      <= 1'b0;
      end else if (w_accept) begin
         r_mcand <= op_a;
         r_mq    <= op_b;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         {r_acc, r_mq} <= w_shift;
         r_cnt         <= r_cnt + 1'b1;
         if (w_last) begin
            r_product <= w_shift;
            r_cf      <= |w_shift[2*WIDTH-1:WIDTH];
            r_zf      <= (w_shift == '0);
         end
      end
   end

   always_comb begin
      busy    = (r_state == S_RUN);
      done    = (r_state == S_DONE);
      product = r_product;
      cf      = r_cf;
      zf      = r_zf;
   end

endmodule
